// File: rtl/ftsd_name_scroller.sv
// ---------------------------------------------------------------------------
// ftsd_name_scroller
//
// Scan and marquee controller for the 4-digit 14-segment song-name display.
// Presents a character index to the external name decoder, registers the
// returned pattern and drives the digit-select and segment pins. The six
// character name scrolls through the four-digit window: hold at the start,
// step one character at a time, hold at the end, then jump back. Any change
// of the selected song restarts the marquee without disturbing the scan.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   song[2:0]   selected song 0..5 (other codes blank through the decoder)
//   display     decoder pattern for the current `value`, active-low
//   value       character index sent to the decoder (scroll_pos + digit)
//   ftsd_ctl    digit enables, active-low, bit3 = leftmost digit 0
//   ftsd_seg    registered segment pattern, active-low
//   scroll_pos  current window offset 0..NAME_LEN-4
//
// Build option
//   FTSD_DIM_EN  when defined, digit enables are blanked for the second half
//                of every refresh slot (50% brightness); segments unaffected.
//
// Marquee states
//   state      | meaning
//   -----------+------------------------------------------------------------
//   HOLD_START | window at offset 0, waiting HOLD_FRAMES frames
//   SCROLL     | stepping the window one character per SCROLL_FRAMES frames
//   HOLD_END   | window at the last offset, waiting HOLD_FRAMES frames
// ---------------------------------------------------------------------------
module ftsd_name_scroller #(
  parameter logic [15:0] REFRESH_DIV   = 16'd50000,
  parameter logic [7:0]  SCROLL_FRAMES = 8'd100,
  parameter logic [7:0]  HOLD_FRAMES   = 8'd200,
  parameter logic [2:0]  NAME_LEN      = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  song,
  input  logic [14:0] display,
  output logic [2:0]  value,
  output logic [3:0]  ftsd_ctl,
  output logic [14:0] ftsd_seg,
  output logic [1:0]  scroll_pos
);

  localparam logic [1:0] MAX_OFS = 2'(NAME_LEN - 3'd4);

  typedef enum logic [1:0] {
    HOLD_START = 2'd0,
    SCROLL     = 2'd1,
    HOLD_END   = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Scan path registers
  // -------------------------------------------------------------------------
  logic [15:0] cnt_q,   cnt_d;
  logic [1:0]  digit_q, digit_d;   // digit whose character is fetched at the next wrap
  logic [1:0]  vdig_q,  vdig_d;    // digit that `value` currently belongs to
  logic        load_q,  load_d;    // one cycle after a wrap: decoder output is valid
  logic [2:0]  value_q, value_d;
  logic [3:0]  ctl_q,   ctl_d;
  logic [14:0] seg_q,   seg_d;
  logic [2:0]  song_q;

  // -------------------------------------------------------------------------
  // Marquee registers
  // -------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [1:0]  ofs_q,   ofs_d;
  logic [7:0]  frame_q, frame_d;

  logic        wrap;
  logic        frame_tick;
  logic        song_chg;
  logic [7:0]  frame_lim;
  logic        limit_hit;
  logic [3:0]  ctl_dec;

  assign wrap       = (cnt_q == (REFRESH_DIV - 16'd1));
  assign frame_tick = wrap && (digit_q == 2'd3);
  assign song_chg   = (song != song_q);

  assign frame_lim  = (state_q == SCROLL) ? SCROLL_FRAMES : HOLD_FRAMES;
  assign limit_hit  = (frame_q == (frame_lim - 8'd1));

  // -------------------------------------------------------------------------
  // Refresh scan
  //
  // At each slot wrap the character for digit_q is requested from the
  // decoder using the offset of the frame that is ending; the pattern comes
  // back during the following cycle and is latched together with the
  // matching digit enable, so seg and ctl always change as a pair. The
  // previous digit simply stays lit one extra cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    ctl_dec = 4'b1111;
    case (vdig_q)
      2'd0:    ctl_dec = 4'b0111;
      2'd1:    ctl_dec = 4'b1011;
      2'd2:    ctl_dec = 4'b1101;
      default: ctl_dec = 4'b1110;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    digit_d = digit_q;
    vdig_d  = vdig_q;
    value_d = value_q;
    load_d  = wrap;
    seg_d   = seg_q;
    ctl_d   = ctl_q;

    if (wrap) begin
      cnt_d   = 16'd0;
      digit_d = digit_q + 2'd1;
      vdig_d  = digit_q;
      // Largest offset plus largest digit is 5, so 3 bits never overflow.
      value_d = {1'b0, ofs_q} + {1'b0, digit_q};
    end

    if (load_q) begin
      seg_d = display;
      ctl_d = ctl_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 16'd0;
      digit_q <= 2'd0;
      vdig_q  <= 2'd0;
      load_q  <= 1'b0;
      value_q <= 3'd0;
      ctl_q   <= 4'b1111;
      seg_q   <= 15'h7FFF;
      song_q  <= song;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      vdig_q  <= vdig_d;
      load_q  <= load_d;
      value_q <= value_d;
      ctl_q   <= ctl_d;
      seg_q   <= seg_d;
      song_q  <= song;
    end
  end

  // -------------------------------------------------------------------------
  // Marquee FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD_START;
      ofs_q   <= 2'd0;
      frame_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ofs_q   <= ofs_d;
      frame_q <= frame_d;
    end
  end

  // -------------------------------------------------------------------------
  // Marquee FSM: next state
  // A song change overrides whatever the frame tick would have done.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (song_chg) begin
      state_d = HOLD_START;
    end else if (frame_tick && limit_hit) begin
      case (state_q)
        HOLD_START: state_d = SCROLL;
        SCROLL:     state_d = (ofs_q == MAX_OFS) ? HOLD_END : SCROLL;
        HOLD_END:   state_d = HOLD_START;
        default:    state_d = HOLD_START;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Marquee FSM: outputs (window offset and frame counter)
  // The offset only moves on frame ticks so a frame never mixes two offsets.
  // -------------------------------------------------------------------------
  always_comb begin
    ofs_d   = ofs_q;
    frame_d = frame_q;
    if (song_chg) begin
      ofs_d   = 2'd0;
      frame_d = 8'd0;
    end else if (frame_tick) begin
      if (limit_hit) begin
        frame_d = 8'd0;
        case (state_q)
          HOLD_START: ofs_d = 2'd1;
          SCROLL:     ofs_d = (ofs_q == MAX_OFS) ? ofs_q : ofs_q + 2'd1;
          HOLD_END:   ofs_d = 2'd0;
          default:    ofs_d = 2'd0;
        endcase
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign value      = value_q;
  assign ftsd_seg   = seg_q;
  assign scroll_pos = ofs_q;

`ifdef FTSD_DIM_EN
  localparam logic [15:0] HALF_DIV = REFRESH_DIV >> 1;
  assign ftsd_ctl = (cnt_q >= HALF_DIV) ? 4'b1111 : ctl_q;
`else
  assign ftsd_ctl = ctl_q;
`endif

endmodule
